bpm_test_link_checker: RTL and testbench
========================================

# bpm_test_link_checker

Receive-side checker for the BPM test link. It consumes the AXI stream produced by the BPM test-pattern generator (header / X / Y / S words per BPM, `tlast` on S) in the Aurora user clock domain. Each FA session is checked word by word against the deterministic pattern. A per-session status strobe and code are reported, along with session and error counters for the system-side register bank.

## Interface
- `BPM_COUNT`, 16: packets expected per session; valid range 0..32.
- `CELL_INDEX`, 12: expected 5-bit cell index in the header.
- `BPM_GLOBAL_INDEX`, 2: expected 4-bit FOFB index prefix.
- `auroraUserClk` in 1: the only clock.
- `auroraReset` in 1: reset; synchronous, active-high.
- `auroraFAstrobe` in 1: one-cycle marker for the start of a session.
- `BPM_TEST_AXI_STREAM_RX_tdata` in 32: received word.
- `BPM_TEST_AXI_STREAM_RX_tvalid` in 1: word valid.
- `BPM_TEST_AXI_STREAM_RX_tlast` in 1: last word of a packet.
- `BPM_TEST_AXI_STREAM_RX_tready` out 1: registered; 0 in reset, 1 otherwise. The block never back-pressures.
- `TESTstatusStrobe` out 1: one-cycle pulse at the end of a session.
- `TESTstatusCode` out 2: result code, valid with the strobe and held until the next strobe.
- `sessionCount` out 16: number of status strobes issued; wraps.
- `badSessionCount` out 16: strobes issued with a non-zero code; saturates at 0xFFFF.
- `lastCycleTag` out 16: tag captured in the most recent session.

## Operation
- **Beat**: a cycle with `tvalid & tready`.
- **Expected words for packet k** (k = 0..BPM_COUNT-1):
  - header = {16'hA5BE, 1'b1, CELL_INDEX[4:0], 1'b0, BPM_GLOBAL_INDEX[3:0], k[4:0]}; with the defaults this is 0xA5BEB040+k.
  - X = 0xCAFE0000+k.
  - Y = 0xBEEF0000+k.
  - S = {tag, 11'b0, k}.
  - `tlast` is set only on S.
- **Tag rules**:
  - The tag is S[31:16] of packet 0, captured into `lastCycleTag`.
  - Later packets in the same session must carry the same tag.
  - If a previous session's tag is valid, the new tag must equal the previous tag+1 (mod 2^16). Otherwise the data-error flag is set.
  - The tag-valid flag is cleared by reset.
- **States**:
  - IDLE: discard beats. Exit only on `auroraFAstrobe`.
  - HDR, X, Y, S: check one word per beat, then advance HDR→X→Y→S→HDR.
  - RESYNC: discard beats until a beat with `tlast`.
  - DONE: session complete.
- **Transitions**:
  - `auroraFAstrobe` always wins, in every state:
    - If the state is HDR/X/Y/S/RESYNC with packet count < BPM_COUNT, emit strobe code 3.
    - Then clear the packet counter and the session error flags, and go to HDR. If BPM_COUNT==0, go to IDLE instead.
    - A beat coincident with the strobe is discarded.
  - Word mismatch in any of HDR/X/Y/S: set the sticky data-error flag.
  - A beat with `tlast` in HDR/X/Y:
    - set the framing flag;
    - the packet ends: counter++, state goes to HDR.
  - S beat without `tlast`: set the framing flag, counter++, go to RESYNC. In RESYNC, a `tlast` beat returns to HDR without incrementing the counter.
  - Packet counter reaches BPM_COUNT:
    - go to DONE and emit the strobe;
    - code 2 if the framing flag is set, else 1 if the data flag is set, else 0.
  - In DONE, the first beat before the next FA strobe emits strobe code 3 and stays in DONE. Later beats are discarded silently.
- **Counters**: `sessionCount` increments on every strobe. `badSessionCount` increments when the code is non-zero.

## Timing
- Status is registered: the strobe and code appear the cycle after the last S beat, the cycle after a short-session FA strobe, or the cycle after an overrun beat.
- At most one strobe per cycle. Events that would produce a second strobe cannot coincide, because the FA strobe takes priority.
- Reset values:
  - `tready`=0.
  - Strobe 0, code 0.
  - All counters 0, `lastCycleTag`=0, tag-valid 0.
  - State IDLE.
- Reset mid-packet: everything returns to the reset values the next cycle. No strobe is issued for the aborted session.
- The packet counter is 6 bits, so BPM_COUNT=32 does not wrap.

## Test plan
- Reset, FA strobe, 16 correct packets with tag 1, back-to-back:
  - strobe with code 0 exactly one cycle after the 16th S beat;
  - `sessionCount`=1, `badSessionCount`=0, `lastCycleTag`=1.
- Same session, but packet 5 X word = 0xCAFE0006: strobe with code 1 at session end, `badSessionCount`=1.
- `tlast` on the Y word of packet 3, all other packets correct: code 2; packets 4..15 are still checked and accepted.
- FA strobe after 10 packets: strobe code 3 the following cycle, then the new session is checked from header 0xA5BEB040.
- Two full sessions with tags 1 then 3: first session code 0, second code 1. Then 17 packets in one session: code 0 after packet 16, then code 3 on the first beat of packet 17.
- Assert reset during packet 7 X: outputs return to reset values, beats are discarded until the FA strobe, and the next session passes with code 0 (tag check skipped).

Source files
------------

// File: rtl/bpm_test_link_checker_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : bpm_test_link_checker_if
// Brief    : AXI stream carrying BPM test-link words (header/X/Y/S).
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
interface bpm_test_link_checker_if;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tlast;
  logic        tready;

  modport master (output tdata, output tvalid, output tlast, input  tready);
  modport slave  (input  tdata, input  tvalid, input  tlast, output tready);
endinterface
`default_nettype wire

// File: rtl/bpm_test_link_checker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : bpm_test_link_checker
// Brief    : Checks each FA session of the BPM test link against the
//            deterministic pattern; reports per-session status and counters.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module bpm_test_link_checker #(
  parameter int BPM_COUNT        = 16,
  parameter int CELL_INDEX       = 12,
  parameter int BPM_GLOBAL_INDEX = 2
) (
  input  wire logic              auroraUserClk,
  input  wire logic              auroraReset,
  input  wire logic              auroraFAstrobe,
  bpm_test_link_checker_if.slave BPM_TEST_AXI_STREAM_RX,
  output logic                   TESTstatusStrobe,
  output logic [1:0]             TESTstatusCode,
  output logic [15:0]            sessionCount,
  output logic [15:0]            badSessionCount,
  output logic [15:0]            lastCycleTag
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HDR    = 3'd1,
    S_X      = 3'd2,
    S_Y      = 3'd3,
    S_S      = 3'd4,
    S_RESYNC = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  localparam logic [5:0]  c_BPM_COUNT = 6'(BPM_COUNT);
  localparam logic [26:0] c_HDR_HI    = {16'hA5BE, 1'b1, 5'(CELL_INDEX), 1'b0, 4'(BPM_GLOBAL_INDEX)};

  state_t      r_state, w_state;
  logic [5:0]  r_pktCount, w_pktCount;
  logic        r_dataErr, w_dataErr;
  logic        r_frameErr, w_frameErr;
  logic        r_overrun, w_overrun;
  logic        r_tagValid, w_tagValid;
  logic [15:0] r_lastCycleTag, w_lastCycleTag;
  logic        r_tready;
  logic        r_statusStrobe, w_strobe;
  logic [1:0]  r_statusCode, w_code;
  logic [15:0] r_sessionCount, r_badSessionCount;
  logic        w_inc;

  logic [31:0] w_data;
  logic        w_beat;
  logic [4:0]  w_k;
  logic [15:0] w_expTag;

  assign w_data = BPM_TEST_AXI_STREAM_RX.tdata;
  assign w_beat = BPM_TEST_AXI_STREAM_RX.tvalid & r_tready;
  assign w_k    = r_pktCount[4:0];
  // Packet 0 defines the session tag; it must follow the previous one when known.
  assign w_expTag = (r_pktCount != 6'd0) ? r_lastCycleTag :
                    r_tagValid ? (r_lastCycleTag + 16'd1) : w_data[31:16];

  always_ff @(posedge auroraUserClk) begin
    if (auroraReset) begin
      r_state           <= S_IDLE;
      r_pktCount        <= 6'd0;
      r_dataErr         <= 1'b0;
      r_frameErr        <= 1'b0;
      r_overrun         <= 1'b0;
      r_tagValid        <= 1'b0;
      r_lastCycleTag    <= 16'd0;
      r_tready          <= 1'b0;
      r_statusStrobe    <= 1'b0;
      r_statusCode      <= 2'd0;
      r_sessionCount    <= 16'd0;
      r_badSessionCount <= 16'd0;
    end else begin
      r_state        <= w_state;
      r_pktCount     <= w_pktCount;
      r_dataErr      <= w_dataErr;
      r_frameErr     <= w_frameErr;
      r_overrun      <= w_overrun;
      r_tagValid     <= w_tagValid;
      r_lastCycleTag <= w_lastCycleTag;
      r_tready       <= 1'b1;
      r_statusStrobe <= w_strobe;
      r_statusCode   <= w_code;
      if (w_strobe) begin
        r_sessionCount <= r_sessionCount + 16'd1;
        if (w_code != 2'd0 && r_badSessionCount != 16'hFFFF)
          r_badSessionCount <= r_badSessionCount + 16'd1;
      end
    end
  end

  always_comb begin
    w_state        = r_state;
    w_pktCount     = r_pktCount;
    w_dataErr      = r_dataErr;
    w_frameErr     = r_frameErr;
    w_overrun      = r_overrun;
    w_tagValid     = r_tagValid;
    w_lastCycleTag = r_lastCycleTag;
    w_strobe       = 1'b0;
    w_code         = r_statusCode;
    w_inc          = 1'b0;

    if (auroraFAstrobe) begin
      if (r_state inside {S_HDR, S_X, S_Y, S_S, S_RESYNC} && r_pktCount < c_BPM_COUNT) begin
        w_strobe = 1'b1;
        w_code   = 2'd3;
      end
      w_pktCount = 6'd0;
      w_dataErr  = 1'b0;
      w_frameErr = 1'b0;
      w_overrun  = 1'b0;
      w_state    = (c_BPM_COUNT == 6'd0) ? S_IDLE : S_HDR;
    end else if (w_beat) begin
      case (r_state)
        S_HDR, S_X, S_Y: begin
          if ((r_state == S_HDR && w_data != {c_HDR_HI, w_k}) ||
              (r_state == S_X   && w_data != {16'hCAFE, 11'd0, w_k}) ||
              (r_state == S_Y   && w_data != {16'hBEEF, 11'd0, w_k}))
            w_dataErr = 1'b1;
          if (BPM_TEST_AXI_STREAM_RX.tlast) begin
            w_frameErr = 1'b1;
            w_inc      = 1'b1;
            w_state    = S_HDR;
          end else begin
            w_state = (r_state == S_HDR) ? S_X : (r_state == S_X) ? S_Y : S_S;
          end
        end
        S_S: begin
          if (w_data != {w_expTag, 11'd0, w_k})
            w_dataErr = 1'b1;
          if (r_pktCount == 6'd0) begin
            w_lastCycleTag = w_data[31:16];
            w_tagValid     = 1'b1;
          end
          w_inc = 1'b1;
          if (BPM_TEST_AXI_STREAM_RX.tlast) begin
            w_state = S_HDR;
          end else begin
            w_frameErr = 1'b1;
            w_state    = S_RESYNC;
          end
        end
        S_RESYNC: begin
          if (BPM_TEST_AXI_STREAM_RX.tlast)
            w_state = S_HDR;
        end
        S_DONE: begin
          // Only the first overrun beat of a finished session is reported.
          if (!r_overrun) begin
            w_overrun = 1'b1;
            w_strobe  = 1'b1;
            w_code    = 2'd3;
          end
        end
        default: ;
      endcase

      if (w_inc) begin
        w_pktCount = r_pktCount + 6'd1;
        if (w_pktCount == c_BPM_COUNT) begin
          w_state  = S_DONE;
          w_strobe = 1'b1;
          w_code   = w_frameErr ? 2'd2 : (w_dataErr ? 2'd1 : 2'd0);
        end
      end
    end
  end

  assign BPM_TEST_AXI_STREAM_RX.tready = r_tready;
  assign TESTstatusStrobe = r_statusStrobe;
  assign TESTstatusCode   = r_statusCode;
  assign sessionCount     = r_sessionCount;
  assign badSessionCount  = r_badSessionCount;
  assign lastCycleTag     = r_lastCycleTag;

endmodule
`default_nettype wire

// File: tb/tb_bpm_test_link_checker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_bpm_test_link_checker
// Brief    : Directed self-checking bench for bpm_test_link_checker.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_bpm_test_link_checker;

  logic        auroraUserClk = 1'b0;
  logic        auroraReset   = 1'b1;
  logic        auroraFAstrobe = 1'b0;
  logic        TESTstatusStrobe;
  logic [1:0]  TESTstatusCode;
  logic [15:0] sessionCount;
  logic [15:0] badSessionCount;
  logic [15:0] lastCycleTag;
  int          checks   = 0;
  int          failures = 0;

  bpm_test_link_checker_if rx ();

  bpm_test_link_checker #(
    .BPM_COUNT        (16),
    .CELL_INDEX       (12),
    .BPM_GLOBAL_INDEX (2)
  ) dut (
    .auroraUserClk          (auroraUserClk),
    .auroraReset            (auroraReset),
    .auroraFAstrobe         (auroraFAstrobe),
    .BPM_TEST_AXI_STREAM_RX (rx.slave),
    .TESTstatusStrobe       (TESTstatusStrobe),
    .TESTstatusCode         (TESTstatusCode),
    .sessionCount           (sessionCount),
    .badSessionCount        (badSessionCount),
    .lastCycleTag           (lastCycleTag)
  );

  always #5 auroraUserClk = ~auroraUserClk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge auroraUserClk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  task automatic status(input string name, input logic s, input logic [1:0] c,
                        input logic [15:0] sc, input logic [15:0] bc, input logic [15:0] tg);
    chk({name, "_strobe"}, 32'(TESTstatusStrobe), 32'(s));
    chk({name, "_code"},   32'(TESTstatusCode),   32'(c));
    chk({name, "_sess"},   32'(sessionCount),     32'(sc));
    chk({name, "_bad"},    32'(badSessionCount),  32'(bc));
    chk({name, "_tag"},    32'(lastCycleTag),     32'(tg));
  endtask

  task automatic beat(input logic [31:0] d, input logic l);
    rx.tvalid = 1'b1;
    rx.tdata  = d;
    rx.tlast  = l;
    step();
  endtask

  task automatic pkt(input int k, input logic [15:0] tag, input logic [31:0] xw, input bit lastOnY);
    beat(32'hA5BEB040 + 32'(k), 1'b0);
    beat(xw, 1'b0);
    if (lastOnY) begin
      beat(32'hBEEF0000 + 32'(k), 1'b1);
    end else begin
      beat(32'hBEEF0000 + 32'(k), 1'b0);
      beat({tag, 16'(k)}, 1'b1);
    end
  endtask

  // Sends npk packets; badPkt gets X word CAFE0000+k+1, yPkt ends on its Y word.
  task automatic session(input logic [15:0] tag, input int npk, input int badPkt, input int yPkt);
    for (int k = 0; k < npk; k++) begin
      pkt(k, tag, (k == badPkt) ? 32'hCAFE0001 + 32'(k) : 32'hCAFE0000 + 32'(k), k == yPkt);
      if (k == npk - 2) chk("early_strobe", 32'(TESTstatusStrobe), 32'd0);
    end
    rx.tvalid = 1'b0;
    rx.tlast  = 1'b0;
  endtask

  task automatic faPulse();
    rx.tvalid      = 1'b0;
    rx.tlast       = 1'b0;
    auroraFAstrobe = 1'b1;
    step();
    auroraFAstrobe = 1'b0;
  endtask

  initial begin
    rx.tvalid = 1'b0;
    rx.tlast  = 1'b0;
    rx.tdata  = 32'd0;

    // Reset state
    step();
    step();
    chk("reset_tready", 32'(rx.tready), 32'd0);
    status("reset", 1'b0, 2'd0, 16'd0, 16'd0, 16'd0);
    auroraReset = 1'b0;
    step();
    chk("run_tready", 32'(rx.tready), 32'd1);

    // Clean session, tag 1
    faPulse();
    chk("fa_no_strobe", 32'(TESTstatusStrobe), 32'd0);
    session(16'd1, 16, -1, -1);
    status("s1", 1'b1, 2'd0, 16'd1, 16'd0, 16'd1);
    step();
    chk("s1_pulse_end", 32'(TESTstatusStrobe), 32'd0);
    chk("s1_code_held", 32'(TESTstatusCode), 32'd0);

    // Packet 5 X word = CAFE0006 -> data error
    faPulse();
    chk("fa_after_done", 32'(TESTstatusStrobe), 32'd0);
    session(16'd2, 16, 5, -1);
    status("s2", 1'b1, 2'd1, 16'd2, 16'd1, 16'd2);

    // tlast on Y of packet 3 -> framing error
    faPulse();
    session(16'd3, 16, -1, 3);
    status("s3", 1'b1, 2'd2, 16'd3, 16'd2, 16'd3);

    // FA strobe after 10 packets -> short session
    faPulse();
    session(16'd4, 10, -1, -1);
    faPulse();
    status("short", 1'b1, 2'd3, 16'd4, 16'd3, 16'd4);
    session(16'd5, 16, -1, -1);
    status("after_short", 1'b1, 2'd0, 16'd5, 16'd3, 16'd5);

    // Tag sequence 6 then 8: second session breaks the increment rule
    faPulse();
    session(16'd6, 16, -1, -1);
    status("tag6", 1'b1, 2'd0, 16'd6, 16'd3, 16'd6);
    faPulse();
    session(16'd8, 16, -1, -1);
    status("tag8", 1'b1, 2'd1, 16'd7, 16'd4, 16'd8);

    // 17 packets: code 0 after 16th, code 3 on first overrun beat, then silence
    faPulse();
    session(16'd9, 16, -1, -1);
    status("s17_main", 1'b1, 2'd0, 16'd8, 16'd4, 16'd9);
    beat(32'hA5BEB050, 1'b0);
    status("overrun", 1'b1, 2'd3, 16'd9, 16'd5, 16'd9);
    beat(32'hCAFE0010, 1'b0);
    status("overrun_quiet", 1'b0, 2'd3, 16'd9, 16'd5, 16'd9);
    beat(32'hBEEF0010, 1'b0);
    beat({16'd9, 16'd16}, 1'b1);
    status("overrun_quiet2", 1'b0, 2'd3, 16'd9, 16'd5, 16'd9);
    rx.tvalid = 1'b0;
    rx.tlast  = 1'b0;

    // Reset during packet 7 X word
    faPulse();
    session(16'd10, 7, -1, -1);
    beat(32'hA5BEB047, 1'b0);
    auroraReset = 1'b1;
    beat(32'hCAFE0007, 1'b0);
    chk("midrst_tready", 32'(rx.tready), 32'd0);
    status("midrst", 1'b0, 2'd0, 16'd0, 16'd0, 16'd0);
    auroraReset = 1'b0;
    step();
    pkt(0, 16'd11, 32'hCAFE0000, 1'b0);
    rx.tvalid = 1'b0;
    rx.tlast  = 1'b0;
    status("idle_discard", 1'b0, 2'd0, 16'd0, 16'd0, 16'd0);
    faPulse();
    session(16'h004D, 16, -1, -1);
    status("post_rst", 1'b1, 2'd0, 16'd1, 16'd0, 16'h004D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
